// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: request side and register-file write side of the write-port arbiter
interface regfile_write_arbiter_if #(
  parameter int N = 64,
  parameter int NREQ = 4,
  parameter int AW = 5,
  parameter int NREG = 32
);
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic [NREG-1:0] load;
  logic [N-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic addr_err;
  modport master (
    output req, req_addr, req_data,
    input gnt, load, wr_data, wr_addr, addr_err
  );
  modport slave (
    input req, req_addr, req_data,
    output gnt, load, wr_data, wr_addr, addr_err
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register-file write port; define XZR_PROTECT_EN to make address NREG-1 unwritable
module regfile_write_arbiter #(
  parameter int N = 64,
  parameter int NREQ = 4,
  parameter int AW = 5,
  parameter int NREG = 32
) (
  input logic clock,
  input logic R,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic found;
  logic [NREQ-1:0] gnt_q, gnt_d, elig;
  logic [NREG-1:0] load_q, load_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, win_addr;
  logic addr_err_q, addr_err_d, in_range, protect;
  // first eligible requester at or after the pointer, wrapping; the one just granted is masked
  always_comb begin
    elig = bus.req & ~gnt_q;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  // next grant, load decode, write payload and pointer advance
  always_comb begin
    win_addr = bus.req_addr[win*AW +: AW];
    in_range = int'(win_addr) < NREG;
`ifdef XZR_PROTECT_EN
    protect = int'(win_addr) == NREG - 1;
`else
    protect = 1'b0;
`endif
    ptr_d = found ? PW'((int'(win) + 1) % NREQ) : ptr_q;
    gnt_d = found ? NREQ'(1) << win : '0;
    load_d = (found && in_range && !protect) ? NREG'(1) << win_addr : '0;
    addr_err_d = found && !in_range;
    wr_addr_d = found ? win_addr : wr_addr_q;
    wr_data_d = found ? bus.req_data[win*N +: N] : wr_data_q;
  end
  // single registered stage; reset drops any in-flight write immediately
  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      ptr_q <= '0;
      gnt_q <= '0;
      load_q <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      load_q <= load_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      addr_err_q <= addr_err_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.load = load_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus against a behavioural arbiter/register-file model
module tb_regfile_write_arbiter;
  localparam int N = 64, NREQ = 4, AW = 5, NREG = 16;
  logic clock = 1'b0, R = 1'b1;
  int total = 0, bad = 0;
  regfile_write_arbiter_if #(.N(N), .NREQ(NREQ), .AW(AW), .NREG(NREG)) bus ();
  regfile_write_arbiter #(.N(N), .NREQ(NREQ), .AW(AW), .NREG(NREG)) dut (
    .clock(clock), .R(R), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  int mptr;
  logic [NREQ-1:0] mgnt;
  logic [NREG-1:0] mload;
  logic [N-1:0] mdata;
  logic [AW-1:0] maddr;
  logic merr;
  logic [N-1:0] dreg [NREG];
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mptr = 0; mgnt = '0; mload = '0; mdata = '0; maddr = '0; merr = 1'b0;
  endtask
  task automatic model_edge();
    int w, a;
    bit protect;
    if (R) begin
      model_reset();
      return;
    end
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && bus.req[(mptr + k) % NREQ] && !mgnt[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
    if (w < 0) begin
      mgnt = '0; mload = '0; merr = 1'b0;
      return;
    end
    a = int'(bus.req_addr[w*AW +: AW]);
`ifdef XZR_PROTECT_EN
    protect = (a == NREG - 1);
`else
    protect = 1'b0;
`endif
    mgnt = '0; mgnt[w] = 1'b1;
    maddr = AW'(a);
    mdata = bus.req_data[w*N +: N];
    mptr = (w + 1) % NREQ;
    merr = (a >= NREG);
    mload = '0;
    if (a < NREG && !protect) mload[a] = 1'b1;
  endtask
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("gnt", N'(bus.gnt), N'(mgnt));
    chk("load", N'(bus.load), N'(mload));
    chk("wr_data", bus.wr_data, mdata);
    chk("wr_addr", N'(bus.wr_addr), N'(maddr));
    chk("addr_err", N'(bus.addr_err), N'(merr));
    chk("gnt_onehot0", N'($onehot0(bus.gnt)), 64'd1);
    chk("load_onehot0", N'($onehot0(bus.load)), 64'd1);
    chk("load_needs_gnt", N'(bus.load != '0 && bus.gnt == '0), 64'd0);
    for (int j = 0; j < NREG; j++) if (bus.load[j]) dreg[j] = bus.wr_data;
  endtask
  task automatic set_req(input int i, input int a, input logic [N-1:0] d);
    bus.req[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_data[i*N +: N] = d;
  endtask
  initial begin
    bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
    model_reset();
    for (int j = 0; j < NREG; j++) dreg[j] = '0;
    repeat (2) tick();
    chk("rst_gnt", N'(bus.gnt), 64'd0);
    chk("rst_load", N'(bus.load), 64'd0);
    @(negedge clock); R = 1'b0;
    // mid-cycle reset while load[3] is high
    set_req(0, 3, 64'h33);
    tick();
    chk("pre_rst_load3", N'(bus.load), 64'h8);
    bus.req = '0;
    #2 R = 1'b1;
    #1;
    model_reset();
    chk("async_gnt", N'(bus.gnt), 64'd0);
    chk("async_load", N'(bus.load), 64'd0);
    chk("async_wr_data", bus.wr_data, 64'd0);
    chk("async_addr_err", N'(bus.addr_err), 64'd0);
    @(negedge clock); R = 1'b0;
    set_req(0, 2, 64'h5);
    tick();
    chk("post_rst_gnt", N'(bus.gnt), 64'b0001);
    chk("post_rst_load", N'(bus.load), 64'h4);
    bus.req = '0;
    tick();
    // single write, request held one cycle past the grant
    set_req(1, 7, 64'hDEAD_BEEF);
    tick();
    chk("single_gnt", N'(bus.gnt), 64'b0010);
    chk("single_load", N'(bus.load), 64'h80);
    chk("single_data", bus.wr_data, 64'hDEAD_BEEF);
    chk("single_addr", N'(bus.wr_addr), 64'd7);
    tick();
    chk("no_double_gnt", N'(bus.gnt), 64'd0);
    bus.req = '0;
    tick();
    // round robin from ptr=0 after a fresh reset
    @(negedge clock); R = 1'b1;
    tick();
    @(negedge clock); R = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 8, N'(i + 100));
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_gnt", N'(bus.gnt), N'(1) << (k % 4));
    end
    bus.req = '0;
    // same-address conflict: req0 then req2, last write wins
    set_req(0, 5, 64'h11);
    set_req(2, 5, 64'h22);
    tick();
    chk("conf1_gnt", N'(bus.gnt), 64'b0001);
    chk("conf1_load", N'(bus.load), 64'h20);
    chk("conf1_data", bus.wr_data, 64'h11);
    bus.req[0] = 1'b0;
    tick();
    chk("conf2_gnt", N'(bus.gnt), 64'b0100);
    chk("conf2_load", N'(bus.load), 64'h20);
    chk("conf2_data", bus.wr_data, 64'h22);
    bus.req[2] = 1'b0;
    tick();
    chk("conf_final_reg5", dreg[5], 64'h22);
    // out-of-range address
    set_req(1, 20, 64'hABC);
    tick();
    chk("oor_gnt", N'(bus.gnt), 64'b0010);
    chk("oor_load", N'(bus.load), 64'd0);
    chk("oor_err", N'(bus.addr_err), 64'd1);
    bus.req = '0;
    tick();
    chk("oor_err_pulse", N'(bus.addr_err), 64'd0);
    // zero register at NREG-1
    set_req(3, NREG - 1, 64'h77);
    tick();
    chk("xzr_gnt", N'(bus.gnt), 64'b1000);
    chk("xzr_err", N'(bus.addr_err), 64'd0);
`ifdef XZR_PROTECT_EN
    chk("xzr_load", N'(bus.load), 64'd0);
`else
    chk("xzr_load", N'(bus.load), 64'h8000);
`endif
    bus.req = '0;
    tick();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && mgnt[i]) begin
          if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, int'($urandom_range(0, 2**AW - 1)), {$urandom, $urandom});
        end
      end
      if (c == 1500) begin
        @(negedge clock); R = 1'b1;
        tick();
        @(negedge clock); R = 1'b0;
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
